ysyx_wbu: RTL and testbench

- Writeback unit directly upstream of the integer register file write port.
- Accepts completed results from two producers: EXU (ALU/CSR results) and LSU (load data).
- Arbitrates to one result per cycle and registers it into a single writeback stage.
- Drives the register-file write port, the decode-side bypass, scoreboard release and a retire counter from that stage.

---
 rtl/ysyx_wbu_pkg.sv | 28 ++
 rtl/ysyx_wbu_arb.sv | 50 +++++
 rtl/ysyx_wbu.sv | 167 ++++++++++++++++
 tb/tb_ysyx_wbu.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_wbu_pkg.sv
// Shared types and widths for the ysyx writeback unit.
// Data width and significant register-index bits come from YSYX_XLEN / YSYX_REG_LEN.
`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif
`ifndef YSYX_REG_LEN
`define YSYX_REG_LEN 5
`endif

package ysyx_wbu_pkg;

  localparam int unsigned XLEN     = `YSYX_XLEN;
  localparam int unsigned REG_LEN  = `YSYX_REG_LEN;
  localparam int unsigned STARVE_W = 4;

  typedef struct packed {
    logic            valid;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
    logic [XLEN-1:0] pc;
  } wb_entry_t;

  // Indices whose significant bits are all zero alias x0 and must not be written.
  function automatic logic rd_aliases_x0(input logic [4:0] rd);
    return (rd[REG_LEN-1:0] == {REG_LEN{1'b0}});
  endfunction

endpackage

// File: rtl/ysyx_wbu_arb.sv
// Two-way writeback arbiter: LSU has priority, EXU is forced through after
// STARVE_MAX consecutive denied cycles.
module ysyx_wbu_arb
  import ysyx_wbu_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic exu_valid_i,
  input  logic lsu_valid_i,
  output logic grant_exu_o,
  output logic grant_lsu_o
);

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] starve_q;
  logic [STARVE_W-1:0] starve_d;
  logic                force_exu_s;

  // Grants are held off during reset so producers retry once it is released.
  always_comb begin
    force_exu_s = exu_valid_i && (starve_q == STARVE_LIM);
    grant_lsu_o = lsu_valid_i && !force_exu_s && !rst_i;
    grant_exu_o = exu_valid_i && !grant_lsu_o && !rst_i;
  end

  // Saturating count of consecutive cycles EXU was left waiting.
  always_comb begin
    starve_d = starve_q;
    if (grant_exu_o || !exu_valid_i) begin
      starve_d = {STARVE_W{1'b0}};
    end else if (starve_q != STARVE_LIM) begin
      starve_d = starve_q + {{(STARVE_W-1){1'b0}}, 1'b1};
    end else begin
      starve_d = starve_q;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_q <= {STARVE_W{1'b0}};
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/ysyx_wbu.sv
// Writeback unit: arbitrates EXU/LSU results into one stage feeding the register
// file, bypass, scoreboard release and retire counter. YSYX_WBU_DIFFTEST_EN adds commit ports.
module ysyx_wbu
  import ysyx_wbu_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 3,
  parameter int unsigned RETIRE_W   = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                exu_valid,
  output logic                exu_ready,
  input  logic [4:0]          exu_rd,
  input  logic [XLEN-1:0]     exu_data,
  input  logic [XLEN-1:0]     exu_pc,
  input  logic                lsu_valid,
  output logic                lsu_ready,
  input  logic [4:0]          lsu_rd,
  input  logic [XLEN-1:0]     lsu_data,
  input  logic [XLEN-1:0]     lsu_pc,
  output logic                rf_write_en,
  output logic [4:0]          rf_waddr,
  output logic [XLEN-1:0]     rf_wdata,
  output logic                byp_valid,
  output logic [4:0]          byp_rd,
  output logic [XLEN-1:0]     byp_data,
  output logic                rel_valid,
  output logic [4:0]          rel_rd,
  output logic [RETIRE_W-1:0] retire_cnt
`ifdef YSYX_WBU_DIFFTEST_EN
  ,
  output logic                commit_valid,
  output logic [XLEN-1:0]     commit_pc
`endif
);

  logic                grant_exu_s;
  logic                grant_lsu_s;
  logic                wr_en_s;
  logic                wb_live_s;
  wb_entry_t           wb_q;
  wb_entry_t           wb_d;
  logic [RETIRE_W-1:0] retire_q;
  logic [RETIRE_W-1:0] retire_d;

  ysyx_wbu_arb #(
    .STARVE_MAX (STARVE_MAX)
  ) u_arb (
    .clk_i       (clock),
    .rst_i       (reset),
    .exu_valid_i (exu_valid),
    .lsu_valid_i (lsu_valid),
    .grant_exu_o (grant_exu_s),
    .grant_lsu_o (grant_lsu_s)
  );

  assign exu_ready = grant_exu_s;
  assign lsu_ready = grant_lsu_s;

  // Stage next-state: the granted result, or an empty slot.
  always_comb begin
    wb_d.valid = 1'b0;
    wb_d.rd    = 5'd0;
    wb_d.data  = {XLEN{1'b0}};
    wb_d.pc    = {XLEN{1'b0}};
    if (grant_lsu_s) begin
      wb_d.valid = 1'b1;
      wb_d.rd    = lsu_rd;
      wb_d.data  = lsu_data;
`ifdef YSYX_WBU_DIFFTEST_EN
      wb_d.pc    = lsu_pc;
`endif
    end else if (grant_exu_s) begin
      wb_d.valid = 1'b1;
      wb_d.rd    = exu_rd;
      wb_d.data  = exu_data;
`ifdef YSYX_WBU_DIFFTEST_EN
      wb_d.pc    = exu_pc;
`endif
    end else begin
      wb_d.valid = 1'b0;
    end
  end

  // Retire counter next-state; wraps naturally at 2^RETIRE_W.
  always_comb begin
    if (wb_q.valid) begin
      retire_d = retire_q + {{(RETIRE_W-1){1'b0}}, 1'b1};
    end else begin
      retire_d = retire_q;
    end
  end

  // Writeback stage and retire counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      wb_q.valid <= 1'b0;
      wb_q.rd    <= 5'd0;
      wb_q.data  <= {XLEN{1'b0}};
      wb_q.pc    <= {XLEN{1'b0}};
      retire_q   <= {RETIRE_W{1'b0}};
    end else begin
      wb_q     <= wb_d;
      retire_q <= retire_d;
    end
  end

  // An entry still in the stage when reset arrives is discarded, not written.
  assign wb_live_s   = wb_q.valid && !reset;
  assign wr_en_s     = wb_live_s && !rd_aliases_x0(wb_q.rd);

  assign rf_write_en = wr_en_s;
  assign rf_waddr    = wb_q.rd;
  assign rf_wdata    = wb_q.data;
  assign byp_valid   = wr_en_s;
  assign byp_rd      = wb_q.rd;
  assign byp_data    = wb_q.data;
  assign rel_valid   = wb_live_s;
  assign rel_rd      = wb_q.rd;
  assign retire_cnt  = retire_q;

`ifdef YSYX_WBU_DIFFTEST_EN
  assign commit_valid = wb_live_s;
  assign commit_pc    = wb_q.pc;

  ysyx_wbu_chk u_chk (
    .clock     (clock),
    .reset     (reset),
    .exu_valid (exu_valid),
    .exu_ready (exu_ready)
  );
`else
  logic unused_pc_s;
  assign unused_pc_s = ^{exu_pc, lsu_pc, wb_q.pc};
`endif

endmodule

`ifdef YSYX_WBU_DIFFTEST_EN
// Simulation check: an EXU request must not be withdrawn before it is accepted.
module ysyx_wbu_chk (
  input logic clock,
  input logic reset,
  input logic exu_valid,
  input logic exu_ready
);

  logic waiting_q;

  // Remember an EXU request left pending at the end of the cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      waiting_q <= 1'b0;
    end else begin
      waiting_q <= exu_valid && !exu_ready;
    end
  end

  // Flag a pending request that disappeared.
  always @(posedge clock) begin
    if (!reset && waiting_q && !exu_valid) begin
      $error("ysyx_wbu: exu_valid dropped without exu_ready");
    end
  end

endmodule
`endif

// File: tb/tb_ysyx_wbu.sv
// Randomised scoreboard bench for ysyx_wbu with a behavioural arbitration model.
module tb_ysyx_wbu;
  import ysyx_wbu_pkg::*;

  localparam int STARVE_MAX = 3;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            exu_valid = 1'b0, lsu_valid = 1'b0;
  logic [4:0]      exu_rd = 5'd0, lsu_rd = 5'd0;
  logic [XLEN-1:0] exu_data = '0, exu_pc = '0, lsu_data = '0, lsu_pc = '0;
  logic            exu_ready, lsu_ready, rf_write_en, byp_valid, rel_valid;
  logic [4:0]      rf_waddr, byp_rd, rel_rd;
  logic [XLEN-1:0] rf_wdata, byp_data;
  logic [63:0]     retire_cnt;
  logic            w4_unused_exu_ready, w4_unused_lsu_ready, w4_unused_we, w4_unused_bv, w4_unused_rv;
  logic [4:0]      w4_unused_waddr, w4_unused_brd, w4_unused_rrd;
  logic [XLEN-1:0] w4_unused_wdata, w4_unused_bdata;
  logic [3:0]      retire4;
`ifdef YSYX_WBU_DIFFTEST_EN
  logic            commit_valid, w4_unused_cv;
  logic [XLEN-1:0] commit_pc, w4_unused_cpc;
`endif

  always #5 clock = ~clock;

  ysyx_wbu #(.STARVE_MAX(STARVE_MAX), .RETIRE_W(64)) dut (
    .clock(clock), .reset(reset),
    .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd), .exu_data(exu_data), .exu_pc(exu_pc),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_pc(lsu_pc),
    .rf_write_en(rf_write_en), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .byp_valid(byp_valid), .byp_rd(byp_rd), .byp_data(byp_data),
    .rel_valid(rel_valid), .rel_rd(rel_rd), .retire_cnt(retire_cnt)
`ifdef YSYX_WBU_DIFFTEST_EN
    , .commit_valid(commit_valid), .commit_pc(commit_pc)
`endif
  );

  ysyx_wbu #(.STARVE_MAX(STARVE_MAX), .RETIRE_W(4)) dut_w4 (
    .clock(clock), .reset(reset),
    .exu_valid(exu_valid), .exu_ready(w4_unused_exu_ready), .exu_rd(exu_rd), .exu_data(exu_data), .exu_pc(exu_pc),
    .lsu_valid(lsu_valid), .lsu_ready(w4_unused_lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_pc(lsu_pc),
    .rf_write_en(w4_unused_we), .rf_waddr(w4_unused_waddr), .rf_wdata(w4_unused_wdata),
    .byp_valid(w4_unused_bv), .byp_rd(w4_unused_brd), .byp_data(w4_unused_bdata),
    .rel_valid(w4_unused_rv), .rel_rd(w4_unused_rrd), .retire_cnt(retire4)
`ifdef YSYX_WBU_DIFFTEST_EN
    , .commit_valid(w4_unused_cv), .commit_pc(w4_unused_cpc)
`endif
  );

  typedef struct {
    int              stamp;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
    logic [XLEN-1:0] pc;
  } exp_t;

  exp_t            q[$];
  int              cyc = 0;
  int              checks = 0;
  int              errors = 0;
  longint unsigned exp_ret = 0;
  bit              prev_rst = 1'b0;

  // Producer-side model state: a pending result per source and EXU wait length.
  bit              e_pend = 1'b0, l_pend = 1'b0;
  logic [4:0]      e_rd = 5'd0, l_rd = 5'd0;
  logic [XLEN-1:0] e_data = '0, e_pc = '0, l_data = '0, l_pc = '0;
  int              exu_waited = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic new_exu(input logic [4:0] rd, input logic [XLEN-1:0] d);
    e_pend = 1'b1; e_rd = rd; e_data = d; e_pc = XLEN'($urandom);
  endtask

  task automatic new_lsu(input logic [4:0] rd, input logic [XLEN-1:0] d);
    l_pend = 1'b1; l_rd = rd; l_data = d; l_pc = XLEN'($urandom);
  endtask

  // One cycle: present pending results, decide the winner from the rules, log it.
  task automatic step(input bit rst);
    bit forced, gl, ge;
    @(posedge clock); #1;
    reset     = rst;
    exu_valid = e_pend; exu_rd = e_rd; exu_data = e_data; exu_pc = e_pc;
    lsu_valid = l_pend; lsu_rd = l_rd; lsu_data = l_data; lsu_pc = l_pc;
    #1;
    forced = e_pend && (exu_waited == STARVE_MAX);
    gl = l_pend && !forced && !rst;
    ge = e_pend && !gl && !rst;
    chk("exu_ready", 64'(exu_ready), 64'(ge));
    chk("lsu_ready", 64'(lsu_ready), 64'(gl));
    if (rst || ge || !e_pend) exu_waited = 0;
    else if (exu_waited < STARVE_MAX) exu_waited++;
    if (gl) begin
      q.push_back('{cyc, l_rd, l_data, l_pc});
      l_pend = 1'b0;
    end else if (ge) begin
      q.push_back('{cyc, e_rd, e_data, e_pc});
      e_pend = 1'b0;
    end
  endtask

  // Monitor: every result granted in cycle N must appear on the write side in N+1.
  always @(negedge clock) begin
    exp_t e;
    bit   exp_now, wen;
    if (reset) begin
      chk("rst_rel_valid", 64'(rel_valid), 64'd0);
      chk("rst_rf_write_en", 64'(rf_write_en), 64'd0);
      while (q.size() > 0 && q[0].stamp < cyc) void'(q.pop_front());
      exp_ret  = 0;
      prev_rst = 1'b1;
    end else begin
      if (prev_rst) begin
        chk("post_rst_waddr", 64'(rf_waddr), 64'd0);
        chk("post_rst_wdata", 64'(rf_wdata), 64'd0);
        chk("post_rst_rel_rd", 64'(rel_rd), 64'd0);
      end
      prev_rst = 1'b0;
      chk("retire_cnt", retire_cnt, exp_ret);
      chk("retire_cnt_w4", 64'(retire4), exp_ret % 64'd16);
      exp_now = (q.size() > 0) && (q[0].stamp < cyc);
      chk("rel_valid", 64'(rel_valid), 64'(exp_now));
      if (exp_now) begin
        e   = q.pop_front();
        wen = (e.rd[REG_LEN-1:0] != '0);
        chk("latency", 64'(e.stamp), 64'(cyc - 1));
        chk("rel_rd", 64'(rel_rd), 64'(e.rd));
        chk("rf_write_en", 64'(rf_write_en), 64'(wen));
        chk("rf_waddr", 64'(rf_waddr), 64'(e.rd));
        chk("rf_wdata", 64'(rf_wdata), 64'(e.data));
        chk("byp_valid", 64'(byp_valid), 64'(wen));
        chk("byp_rd", 64'(byp_rd), 64'(e.rd));
        chk("byp_data", 64'(byp_data), 64'(e.data));
`ifdef YSYX_WBU_DIFFTEST_EN
        chk("commit_pc", 64'(commit_pc), 64'(e.pc));
`endif
        exp_ret++;
      end else begin
        chk("idle_rf_write_en", 64'(rf_write_en), 64'd0);
        chk("idle_byp_valid", 64'(byp_valid), 64'd0);
      end
    end
  end

  initial begin
    repeat (3) step(1'b1);
    step(1'b0);

    // Single EXU result, then an LSU result to x0.
    new_exu(5'd5, XLEN'(32'hDEAD_BEEF));
    step(1'b0);
    step(1'b0);
    new_lsu(5'd0, XLEN'(32'h0000_1234));
    step(1'b0);
    repeat (2) step(1'b0);

    // Continuous contention: LSU x3, EXU forced, LSU, ...
    for (int i = 0; i < 10; i++) begin
      if (!e_pend) new_exu(5'($urandom_range(1, 31)), XLEN'($urandom));
      if (!l_pend) new_lsu(5'($urandom_range(1, 31)), XLEN'($urandom));
      step(1'b0);
    end
    while (e_pend || l_pend) step(1'b0);
    step(1'b0);

    // Reset while an EXU rd=7 result sits in the stage.
    new_exu(5'd7, XLEN'(32'hCAFE_0007));
    step(1'b0);
    step(1'b1);
    step(1'b0);

    // 17 back-to-back alternating results: 4-bit counter wraps to 1.
    for (int i = 0; i < 17; i++) begin
      if (i % 2 == 0) new_exu(5'($urandom_range(0, 31)), XLEN'($urandom));
      else            new_lsu(5'($urandom_range(0, 31)), XLEN'($urandom));
      step(1'b0);
    end
    repeat (3) step(1'b0);
    chk("retire_after_17", retire_cnt, 64'd17);
    chk("retire_w4_wrap", 64'(retire4), 64'd1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if (!e_pend && $urandom_range(0, 99) < 60) new_exu(5'($urandom_range(0, 31)), XLEN'($urandom));
      if (!l_pend && $urandom_range(0, 99) < 60) new_lsu(5'($urandom_range(0, 31)), XLEN'($urandom));
      step($urandom_range(0, 199) == 0);
    end
    for (int i = 0; i < 20 && (e_pend || l_pend); i++) step(1'b0);
    repeat (3) step(1'b0);
    chk("pending_drained", 64'(e_pend || l_pend), 64'd0);
    chk("scoreboard_empty", 64'(q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
